// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked scheduler that shares one UART transmitter among NREQ
// byte-stream requesters, with an optional starvation timeout on a locked grant.
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_i,
    input  logic [NREQ-1:0]     req_valid_i,
    input  logic [8*NREQ-1:0]   req_byte_i,
    input  logic [NREQ-1:0]     req_last_i,
    output logic [NREQ-1:0]     req_ready_o,
    input  logic                tsr_empty_i,
    output logic                tsr_push_o,
    output logic [7:0]          tsr_byte_o,
    output logic [NREQ-1:0]     grant_o,
    output logic                busy_o,
    output logic                timeout_o
);

    localparam int unsigned IdxW    = $clog2(NREQ);
    localparam int unsigned CntW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned CntLast = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {StIdle, StSend, StPush} state_e;

    state_e              state_q;
    logic [NREQ-1:0]     grant_q;
    logic [IdxW-1:0]     gidx_q;
    logic [IdxW-1:0]     last_ptr_q;
    logic                release_q;
    logic [7:0]          byte_q;
    logic [CntW-1:0]     cnt_q;
    logic                push_q;
    logic                busy_q;
    logic                timeout_q;

    logic                pick_found;
    logic [IdxW-1:0]     pick_idx;
    logic [IdxW-1:0]     cand;
    logic                g_valid;
    logic                g_last;
    logic [7:0]          g_byte;
    logic                send_ok;
    logic                accept;

    // First valid requester after the previous owner, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IdxW'((32'(last_ptr_q) + k) % NREQ);
            if (!pick_found && req_valid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign g_valid = req_valid_i[gidx_q];
    assign g_last  = req_last_i[gidx_q];
    assign g_byte  = req_byte_i[{gidx_q, 3'b000} +: 8];
    assign send_ok = (state_q == StSend) && tsr_empty_i && enable_i;
    assign accept  = send_ok && g_valid;

    always_comb begin
        req_ready_o = '0;
        if (send_ok) begin
            req_ready_o = grant_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            gidx_q     <= '0;
            last_ptr_q <= IdxW'(NREQ - 1);
            release_q  <= 1'b0;
            byte_q     <= 8'h00;
            cnt_q      <= '0;
            push_q     <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            push_q    <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enable_i && pick_found) begin
                        grant_q <= NREQ'(1) << pick_idx;
                        gidx_q  <= pick_idx;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (accept) begin
                        byte_q    <= g_byte;
                        release_q <= g_last;
                        cnt_q     <= '0;
                        push_q    <= 1'b1;
                        state_q   <= StPush;
                    end else if (TIMEOUT != 0 && enable_i && !g_valid) begin
                        // Only a silent owner counts as starving; a busy transmitter does not.
                        if (cnt_q == CntW'(CntLast)) begin
                            timeout_q  <= 1'b1;
                            grant_q    <= '0;
                            last_ptr_q <= gidx_q;
                            cnt_q      <= '0;
                            busy_q     <= 1'b0;
                            state_q    <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StPush: begin
                    if (release_q) begin
                        grant_q    <= '0;
                        last_ptr_q <= gidx_q;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end else begin
                        state_q <= StSend;
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tsr_push_o = push_q;
    assign tsr_byte_o = byte_q;
    assign grant_o    = grant_q;
    assign busy_o     = busy_q;
    assign timeout_o  = timeout_q;

endmodule
